// File: rtl/slink_prbs9_checker.sv
// Receive-side PRBS9 checker: self-seeds from the byte stream, locks after LOCK_COUNT
// consecutive matches, counts bit errors while locked and resyncs on an error burst.
module slink_prbs9_checker #(
  parameter int unsigned LOCK_COUNT = 8,
  parameter int unsigned ERR_THRESH = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             data_valid,
  input  logic [7:0]       data,
  input  logic             clear_errors,
  output logic             locked,
  output logic             err_byte,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [2:0] {
    IDLE,
    SEED1,
    SEED2,
    CHECK,
    LOCKED
  } state_t;

  state_t     state;
  logic [8:0] s;
  logic [7:0] b_prev;
  logic [7:0] match_cnt;
  logic [7:0] err_run;

  // Eight steps of the x^9 + x^5 + 1 generator applied in one cycle.
  function automatic logic [8:0] adv(input logic [8:0] p);
    logic [8:0] n;
    n[8] = p[0];
    n[7] = p[8] ^ p[4];
    n[6] = p[7] ^ p[3];
    n[5] = p[6] ^ p[2];
    n[4] = p[5] ^ p[1];
    n[3] = p[4] ^ p[0];
    n[2] = p[3] ^ p[8] ^ p[4];
    n[1] = p[2] ^ p[7] ^ p[3];
    n[0] = p[1] ^ p[6] ^ p[2];
    return n;
  endfunction

  logic [8:0]       s_next;
  logic [7:0]       byte_diff;
  logic [3:0]       bit_errs;
  logic             err_hit;
  logic [8:0]       match_inc;
  logic [8:0]       err_inc;
  logic [8:0]       seed_val;
  logic [ERR_W+3:0] err_sum;
  logic [ERR_W-1:0] err_sat;

  always_comb begin
    s_next    = adv(s);
    byte_diff = data ^ s_next[7:0];
    bit_errs  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      bit_errs = bit_errs + {3'b000, byte_diff[i]};
    end
    err_hit   = enable && data_valid && (state == LOCKED) && (bit_errs != 4'd0);
    match_inc = {1'b0, match_cnt} + 9'd1;
    err_inc   = {1'b0, err_run} + 9'd1;
    seed_val  = {b_prev[0], data};
    err_sum   = (ERR_W+4)'(err_count) + (ERR_W+4)'(bit_errs);
    // Any carry beyond ERR_W bits pins the counter at all-ones.
    err_sat   = (err_sum[ERR_W+3:ERR_W] != 4'd0) ? '1 : err_sum[ERR_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      s         <= '0;
      b_prev    <= '0;
      match_cnt <= '0;
      err_run   <= '0;
      locked    <= 1'b0;
      err_byte  <= 1'b0;
      err_count <= '0;
    end else begin
      err_byte <= err_hit;

      if (clear_errors) begin
        err_count <= '0;
      end else if (err_hit) begin
        err_count <= err_sat;
      end

      if (!enable) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= SEED1;
          end
          SEED1: begin
            if (data_valid) begin
              b_prev <= data;
              state  <= SEED2;
            end
          end
          SEED2: begin
            if (data_valid) begin
              s <= seed_val;
              // An all-zero seed would lock up the predictor; slide the window instead.
              if (seed_val == 9'd0) begin
                b_prev <= data;
              end else begin
                match_cnt <= '0;
                state     <= CHECK;
              end
            end
          end
          CHECK: begin
            if (data_valid) begin
              s <= s_next;
              if (byte_diff == 8'd0) begin
                match_cnt <= match_inc[7:0];
                if (match_inc == 9'(LOCK_COUNT)) begin
                  state   <= LOCKED;
                  locked  <= 1'b1;
                  err_run <= '0;
                end
              end else begin
                state <= SEED1;
              end
            end
          end
          LOCKED: begin
            if (data_valid) begin
              s <= s_next;
              if (bit_errs != 4'd0) begin
                err_run <= err_inc[7:0];
                if (err_inc == 9'(ERR_THRESH)) begin
                  state  <= SEED1;
                  locked <= 1'b0;
                end
              end else begin
                err_run <= '0;
              end
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_slink_prbs9_checker.sv
// Scoreboarded bench for slink_prbs9_checker: a 16-bit and a 4-bit error-counter instance
// share one randomized stimulus stream and are checked against a byte-level reference model.
module tb_slink_prbs9_checker;

  localparam int LOCK = 8;
  localparam int THR  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        data_valid = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        clear_errors = 1'b0;
  logic        locked16, err_byte16, locked4, err_byte4;
  logic [15:0] err_count16;
  logic [3:0]  err_count4;

  always #5 clk = ~clk;

  slink_prbs9_checker #(.LOCK_COUNT(LOCK), .ERR_THRESH(THR), .ERR_W(16)) dut16 (
    .clk(clk), .reset(reset), .enable(enable), .data_valid(data_valid), .data(data),
    .clear_errors(clear_errors), .locked(locked16), .err_byte(err_byte16),
    .err_count(err_count16)
  );

  slink_prbs9_checker #(.LOCK_COUNT(LOCK), .ERR_THRESH(THR), .ERR_W(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .data_valid(data_valid), .data(data),
    .clear_errors(clear_errors), .locked(locked4), .err_byte(err_byte4),
    .err_count(err_count4)
  );

  typedef struct {
    logic        l;
    logic        eb;
    logic [15:0] c16;
    logic [3:0]  c4;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Generator stepped one bit at a time, eight bits per byte.
  function automatic logic [8:0] lfsr8(input logic [8:0] p);
    logic [8:0] q = p;
    for (int k = 0; k < 8; k++) q = {q[7:0], q[8] ^ q[4]};
    return q;
  endfunction

  logic [8:0] tx = 9'h1FF;
  function automatic logic [7:0] tx_byte();
    logic [7:0] b = tx[7:0];
    tx = lfsr8(tx);
    return b;
  endfunction

  // Reference model: mode 0 idle, 1 first seed byte, 2 second seed byte, 3 checking, 4 locked.
  int         m_mode = 0;
  logic [8:0] m_s = '0;
  logic [7:0] m_prev = '0;
  int         m_match = 0, m_run = 0, m_c16 = 0, m_c4 = 0;
  bit         m_eb = 0;

  task automatic model(input bit rst, input bit en, input bit v, input logic [7:0] d,
                       input bit clr);
    logic [8:0] nx;
    int         pc;
    bit         hit;
    exp_t       e;
    if (rst) begin
      m_mode = 0; m_s = '0; m_prev = '0; m_match = 0; m_run = 0;
      m_c16 = 0; m_c4 = 0; m_eb = 0;
    end else begin
      nx  = lfsr8(m_s);
      pc  = $countones(d ^ nx[7:0]);
      hit = en && v && (m_mode == 4) && (pc != 0);
      m_eb = hit;
      if (clr) begin
        m_c16 = 0; m_c4 = 0;
      end else if (hit) begin
        m_c16 = (m_c16 + pc > 65535) ? 65535 : m_c16 + pc;
        m_c4  = (m_c4 + pc > 15) ? 15 : m_c4 + pc;
      end
      if (!en) m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
      else if (v) begin
        case (m_mode)
          1: begin m_prev = d; m_mode = 2; end
          2: begin
            m_s = {m_prev[0], d};
            if (m_s == 0) m_prev = d;
            else begin m_match = 0; m_mode = 3; end
          end
          3: begin
            m_s = nx;
            if (pc == 0) begin
              m_match++;
              if (m_match == LOCK) begin m_mode = 4; m_run = 0; end
            end else m_mode = 1;
          end
          default: begin
            m_s = nx;
            if (pc != 0) begin
              m_run++;
              if (m_run == THR) m_mode = 1;
            end else m_run = 0;
          end
        endcase
      end
    end
    e.l = (m_mode == 4); e.eb = m_eb; e.c16 = 16'(m_c16); e.c4 = 4'(m_c4);
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Applies one cycle of inputs and records the expected post-edge outputs.
  task automatic step(input bit rst, input bit en, input bit v, input logic [7:0] d,
                      input bit clr);
    if (rst) begin
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("async_reset_locked", int'(locked16), 0);
      chk("async_reset_err_byte", int'(err_byte16), 0);
      chk("async_reset_err_count", int'(err_count16), 0);
    end else begin
      reset = 1'b0;
    end
    enable = en; data_valid = v; data = d; clear_errors = clr;
    @(posedge clk);
    model(rst, en, v, d, clr);
    #1;
  endtask

  task automatic send(input int n, input logic [7:0] mask);
    for (int i = 0; i < n; i++) step(0, 1, 1, tx_byte() ^ mask, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("locked", int'(locked16), int'(e.l));
      chk("err_byte", int'(err_byte16), int'(e.eb));
      chk("err_count16", int'(err_count16), int'(e.c16));
      chk("locked_w4", int'(locked4), int'(e.l));
      chk("err_byte_w4", int'(err_byte4), int'(e.eb));
      chk("err_count4", int'(err_count4), int'(e.c4));
    end
  end

  initial begin
    bit         en_r;
    bit         v_r;
    bit         rst_r;
    logic [7:0] d_r;
    logic [7:0] mask;

    step(1, 0, 0, 8'h00, 0);
    step(0, 1, 0, 8'h00, 0);
    tx = 9'h1FF;
    send(9, 8'h00);
    chk("not_locked_after_9", int'(locked16), 0);
    send(1, 8'h00);
    chk("locked_after_10", int'(locked16), 1);
    chk("no_errors_at_lock", int'(err_count16), 0);

    send(1, 8'h01);
    chk("single_bit_err_byte", int'(err_byte16), 1);
    chk("single_bit_count", int'(err_count16), 1);
    chk("single_bit_still_locked", int'(locked16), 1);
    send(1, 8'h00);
    chk("err_byte_one_cycle", int'(err_byte16), 0);

    send(1, 8'hFF);
    chk("byte_err_count", int'(err_count16), 9);
    send(1, 8'h00);
    send(3, 8'hFF);
    chk("locked_before_thresh", int'(locked16), 1);
    send(1, 8'hFF);
    chk("unlock_at_thresh", int'(locked16), 0);
    chk("count_after_burst", int'(err_count16), 41);
    chk("saturated_w4", int'(err_count4), 15);
    send(9, 8'h00);
    chk("not_relocked_after_9", int'(locked16), 0);
    send(1, 8'h00);
    chk("relocked_after_10", int'(locked16), 1);

    step(0, 1, 1, tx_byte() ^ 8'h0F, 1);
    chk("clear_priority16", int'(err_count16), 0);
    chk("clear_priority4", int'(err_count4), 0);

    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'($urandom), 0);
    send(5, 8'h00);
    chk("stall_still_locked", int'(locked16), 1);
    chk("stall_no_errors", int'(err_count16), 0);

    send(1, 8'h03);
    step(0, 0, 1, tx_byte(), 0);
    chk("disable_unlocks", int'(locked16), 0);
    chk("disable_holds_count", int'(err_count16), 2);

    step(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 8'h00, 0);
    send(20, 8'h00);
    chk("relock_after_zero_seed", int'(locked16), 1);

    step(0, 0, 0, 8'h00, 0);
    step(0, 1, 0, 8'h00, 0);
    send(4, 8'h00);
    step(1, 1, 0, 8'h00, 0);

    en_r = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      rst_r = ($urandom_range(0, 999) < 2);
      if (en_r) en_r = ($urandom_range(0, 299) != 0);
      else en_r = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) tx = 9'($urandom_range(1, 511));
      v_r = ($urandom_range(0, 3) != 0);
      if (v_r) begin
        mask = 8'h00;
        if ($urandom_range(0, 11) == 0)
          mask = ($urandom_range(0, 1) == 0) ? 8'(1 << $urandom_range(0, 7))
                                             : 8'($urandom_range(1, 255));
        d_r = tx_byte() ^ mask;
      end else begin
        d_r = 8'($urandom);
      end
      step(rst_r, en_r, v_r, d_r, ($urandom_range(0, 49) == 0));
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
